// File: rtl/sram_bist_sequencer_pkg.sv
// sram_bist_sequencer_pkg: shared state, command types and default bus widths for the SRAM BIST sequencer
package sram_bist_sequencer_pkg;
  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} bist_state_e;
  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_cmd_t;
endpackage

// File: rtl/sram_bist_sequencer_checker.sv
// sram_bist_sequencer_checker: read-back compare, saturating error count, first failing address capture
module sram_bist_sequencer_checker #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              rsp,
  input  logic              tmo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] expected,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  logic err;
  assign err = (rsp && rdata != expected) || tmo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count <= '0;
      first_err_addr <= '0;
    end else if (err) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (err_count == 8'd0) first_err_addr <= addr;
    end
  end
endmodule

// File: rtl/sram_bist_sequencer.sv
// sram_bist_sequencer: writes addr^SEED to NUM_WORDS words, reads them back and reports mismatches/timeouts
module sram_bist_sequencer
  import sram_bist_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = SRAM_ADDR_W,
  parameter int                DATA_W    = SRAM_DATA_W,
  parameter int                NUM_WORDS = 10,
  parameter logic [DATA_W-1:0] SEED      = '0,
  parameter int                TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_V = TW'(TIMEOUT);
  bist_state_e state, state_n;
  logic [ADDR_W:0] idx, idx_n;
  logic [TW-1:0] timer;
  logic start_ok, acc, last, chk_rsp, chk_tmo, wr_n, rd_n;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign acc = cmd_valid && cmd_ready;
  assign last = idx == LAST;
  assign chk_rsp = state == READ_WAIT && rsp_valid;
  assign chk_tmo = state == READ_WAIT && !rsp_valid && timer == TMO_V;
  assign wr_n = state_n == WRITE;
  assign rd_n = state_n == READ_REQ;
  assign pass = done && err_count == 8'd0;
  always_comb begin
    state_n = state;
    idx_n = idx;
    unique case (state)
      IDLE, DONE: if (start_ok) begin
        state_n = WRITE;
        idx_n = '0;
      end
      WRITE: if (acc) begin
        state_n = last ? READ_REQ : WRITE;
        idx_n = last ? '0 : idx + 1'b1;
      end
      READ_REQ: if (acc) state_n = READ_WAIT;
      READ_WAIT: if (chk_rsp || chk_tmo) begin
        state_n = last ? DONE : READ_REQ;
        idx_n = last ? idx : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // command and status outputs are registered from the next state so they hold steady through stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      timer <= '0;
      cmd_valid <= 1'b0;
      cmd_we <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      timer <= (state == READ_WAIT && state_n == READ_WAIT) ? timer + 1'b1 : '0;
      cmd_valid <= wr_n || rd_n;
      cmd_we <= wr_n;
      cmd_addr <= (wr_n || rd_n) ? idx_n[ADDR_W-1:0] : '0;
      cmd_wdata <= wr_n ? idx_n[DATA_W-1:0] ^ SEED : '0;
      busy <= wr_n || rd_n || state_n == READ_WAIT;
      done <= state_n == DONE;
    end
  end
  sram_bist_sequencer_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_checker (
    .clk(clk),
    .rst_n(rst_n),
    .clear(start_ok),
    .rsp(chk_rsp),
    .tmo(chk_tmo),
    .rdata(rsp_rdata),
    .expected(idx[DATA_W-1:0] ^ SEED),
    .addr(idx[ADDR_W-1:0]),
    .err_count(err_count),
    .first_err_addr(first_err_addr)
  );
endmodule

// File: tb/tb_sram_bist_sequencer.sv
// tb_sram_bist_sequencer: scoreboarded SRAM slave model driving two sequencer instances (seed 00 and A5)
module tb_sram_bist_sequencer;
  localparam int AW = 16, DW = 8, N = 10, TMO = 8;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  logic clk = 0, rst_n = 0, start = 0, cmd_ready = 0, rsp_valid = 0;
  logic [DW-1:0] rsp_rdata = 0;
  logic cmd_valid, cmd_we, busy, done, pass;
  logic [AW-1:0] cmd_addr, first_err_addr;
  logic [DW-1:0] cmd_wdata;
  logic [7:0] err_count;
  logic start2 = 0, ready2 = 1, rsp_valid2 = 0;
  logic [DW-1:0] rsp_rdata2 = 0;
  logic cmd_valid2, cmd_we2, busy2, done2, pass2;
  logic [AW-1:0] cmd_addr2, first_err_addr2;
  logic [DW-1:0] cmd_wdata2;
  logic [7:0] err_count2;
  int vectors = 0, miscompares = 0;
  cmd_t exp_q[$], exp2_q[$];
  cmd_t e_cmd, e2_cmd, last_cmd;
  bit rand_ready = 0, spurious = 0, hold = 0;
  int drop_addr = -1, bad_a = -1, bad_b = -1, rd_acc = 0, rsp_cnt = 0, rsp_cnt2 = 0;
  logic [AW-1:0] rsp_addr, rsp_addr2;
  logic [DW-1:0] mem [N], mem2 [N];

  always #5 clk = ~clk;

  sram_bist_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .SEED(8'h00), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr));

  sram_bist_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .SEED(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmd_valid(cmd_valid2), .cmd_ready(ready2),
    .cmd_we(cmd_we2), .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_addr(first_err_addr2));

  // slave for dut: ready/response driven on negedge, accepted commands popped from the scoreboard
  always @(negedge clk) begin
    rsp_valid = 0;
    rsp_rdata = 0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_valid = 1;
        rsp_rdata = (int'(rsp_addr) == bad_a) ? 8'hFF : (int'(rsp_addr) == bad_b) ? ~mem[rsp_addr] : mem[rsp_addr];
      end
    end
    if (hold && rst_n) begin
      vectors++;
      if (cmd_valid !== 1'b1 || {cmd_we, cmd_addr, cmd_wdata} !== last_cmd) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b %h want v=1 %h", cmd_valid, {cmd_we, cmd_addr, cmd_wdata}, last_cmd);
      end
    end
    if (spurious && cmd_valid && cmd_we) begin
      rsp_valid = 1;
      rsp_rdata = 8'hEE;
    end
    cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && cmd_valid && cmd_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cmd_extra: got %h want none", {cmd_we, cmd_addr, cmd_wdata});
      end else begin
        e_cmd = exp_q.pop_front();
        if ({cmd_we, cmd_addr, cmd_wdata} !== e_cmd) begin
          miscompares++;
          $display("FAIL cmd: got %h want %h", {cmd_we, cmd_addr, cmd_wdata}, e_cmd);
        end
      end
      if (cmd_addr < AW'(N)) begin
        if (cmd_we) mem[cmd_addr] = cmd_wdata;
        else begin
          rd_acc++;
          if (int'(cmd_addr) != drop_addr) begin
            rsp_cnt = 2;
            rsp_addr = cmd_addr;
          end
        end
      end
    end
    hold = rst_n && cmd_valid && !cmd_ready;
    last_cmd = {cmd_we, cmd_addr, cmd_wdata};
  end

  // ideal echo slave for dut2
  always @(negedge clk) begin
    rsp_valid2 = 0;
    rsp_rdata2 = 0;
    if (rsp_cnt2 > 0) begin
      rsp_cnt2--;
      if (rsp_cnt2 == 0) begin
        rsp_valid2 = 1;
        rsp_rdata2 = mem2[rsp_addr2];
      end
    end
    if (rst_n && cmd_valid2) begin
      vectors++;
      if (exp2_q.size() == 0) begin
        miscompares++;
        $display("FAIL cmd2_extra: got %h want none", {cmd_we2, cmd_addr2, cmd_wdata2});
      end else begin
        e2_cmd = exp2_q.pop_front();
        if ({cmd_we2, cmd_addr2, cmd_wdata2} !== e2_cmd) begin
          miscompares++;
          $display("FAIL cmd2: got %h want %h", {cmd_we2, cmd_addr2, cmd_wdata2}, e2_cmd);
        end
      end
      if (cmd_addr2 < AW'(N)) begin
        if (cmd_we2) mem2[cmd_addr2] = cmd_wdata2;
        else begin
          rsp_cnt2 = 2;
          rsp_addr2 = cmd_addr2;
        end
      end
    end
  end

  task automatic push_seq(input logic [DW-1:0] seed, input bit second);
    cmd_t c;
    for (int i = 0; i < 2 * N; i++) begin
      c.we = i < N;
      c.addr = AW'(i % N);
      c.wdata = (i < N) ? DW'(i) ^ seed : '0;
      if (second) exp2_q.push_back(c);
      else exp_q.push_back(c);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_timeout: got done=%b want 1", name, done);
    end
  endtask

  task automatic check_result(input string name, input logic p, input logic [7:0] ec, input logic [AW-1:0] fa);
    vectors++;
    if ({done, busy, cmd_valid, pass, err_count, first_err_addr} !== {1'b1, 1'b0, 1'b0, p, ec, fa}) begin
      miscompares++;
      $display("FAIL %s_result: got d=%b b=%b v=%b p=%b ec=%0d fa=%0d want d=1 b=0 v=0 p=%b ec=%0d fa=%0d",
               name, done, busy, cmd_valid, pass, err_count, first_err_addr, p, ec, fa);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_sb: got %0d pending want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({cmd_valid, cmd_we, cmd_addr, cmd_wdata, busy, done, pass, err_count, first_err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero want 0");
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({cmd_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle: got v=%b b=%b d=%b want 000", cmd_valid, busy, done);
    end
  endtask

  task automatic test_ideal;
    push_seq(8'h00, 0);
    pulse_start;
    vectors++;
    if ({cmd_valid, busy, cmd_we} !== 3'b111) begin
      miscompares++;
      $display("FAIL start_latency: got v=%b b=%b we=%b want 111", cmd_valid, busy, cmd_we);
    end
    wait_done("ideal");
    check_result("ideal", 1, 0, 0);
  endtask

  task automatic test_stall;
    rand_ready = 1;
    spurious = 1;
    push_seq(8'h00, 0);
    pulse_start;
    wait_done("stall");
    rand_ready = 0;
    spurious = 0;
    check_result("stall", 1, 0, 0);
  endtask

  task automatic test_corrupt;
    bad_a = 3;
    bad_b = 7;
    push_seq(8'h00, 0);
    pulse_start;
    wait_done("corrupt");
    bad_a = -1;
    bad_b = -1;
    check_result("corrupt", 0, 2, 3);
  endtask

  task automatic test_timeout;
    drop_addr = 5;
    push_seq(8'h00, 0);
    pulse_start;
    wait_done("timeout");
    drop_addr = -1;
    check_result("timeout", 0, 1, 5);
  endtask

  task automatic test_reset_mid;
    int base = rd_acc, c = 0;
    push_seq(8'h00, 0);
    pulse_start;
    while (rd_acc < base + 5 && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    rsp_cnt = 0;
    exp_q.delete();
    vectors++;
    if ({cmd_valid, cmd_we, cmd_addr, cmd_wdata, busy, done, pass, err_count, first_err_addr} !== '0 || c >= 500) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b b=%b d=%b wait=%0d want all 0", cmd_valid, busy, done, c);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    push_seq(8'h00, 0);
    pulse_start;
    wait_done("reset_mid");
    check_result("reset_mid", 1, 0, 0);
  endtask

  task automatic test_busy_start;
    int c = 0;
    push_seq(8'h00, 0);
    pulse_start;
    repeat (3) @(negedge clk);
    pulse_start;
    while (!(busy && !cmd_valid) && c < 200) begin
      @(negedge clk);
      c++;
    end
    pulse_start;
    wait_done("busy_start");
    check_result("busy_start", 1, 0, 0);
  endtask

  task automatic test_seed_restart;
    int c;
    for (int r = 0; r < 2; r++) begin
      push_seq(8'hA5, 1);
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      vectors++;
      if ({done2, cmd_valid2, cmd_wdata2} !== {1'b0, 1'b1, 8'hA5}) begin
        miscompares++;
        $display("FAIL seed_start%0d: got d=%b v=%b wd=%h want d=0 v=1 wd=a5", r, done2, cmd_valid2, cmd_wdata2);
      end
      c = 0;
      while (!done2 && c < 2000) begin
        @(negedge clk);
        c++;
      end
      vectors++;
      if ({done2, pass2, busy2, err_count2} !== {1'b1, 1'b1, 1'b0, 8'd0} || exp2_q.size() != 0) begin
        miscompares++;
        $display("FAIL seed_result%0d: got d=%b p=%b b=%b ec=%0d pend=%0d want d=1 p=1 b=0 ec=0 pend=0",
                 r, done2, pass2, busy2, err_count2, exp2_q.size());
      end
    end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_stall;
    test_corrupt;
    test_timeout;
    test_reset_mid;
    test_busy_start;
    test_seed_restart;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
